// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: op encodings and the shared bitwise evaluation function for logic_gate_pipe
package logic_gate_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_ANDN = 3'd6,
      OP_PASS = 3'd7
   } gate_op_e;

   // Evaluated at full width; callers truncate to their operand width.
   function automatic logic [MAX_W-1:0] gate_eval(input gate_op_e op, input logic [MAX_W-1:0] a,
                                                  input logic [MAX_W-1:0] b);
      gate_eval = a;
      case (op)
         OP_AND:  gate_eval = a & b;
         OP_OR:   gate_eval = a | b;
         OP_XOR:  gate_eval = a ^ b;
         OP_NAND: gate_eval = ~(a & b);
         OP_NOR:  gate_eval = ~(a | b);
         OP_XNOR: gate_eval = ~(a ^ b);
         OP_ANDN: gate_eval = a & ~b;
         OP_PASS: gate_eval = a;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// pipe_stage: one valid/data register that loads when empty or when the stage after it advances
module pipe_stage #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         prev_valid,
   input  logic [W-1:0] prev_data,
   input  logic         next_adv,
   output logic         valid,
   output logic [W-1:0] data
);

   logic adv;

   assign adv = !valid || next_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
      end else if (adv) begin
         valid <= prev_valid;
         if (prev_valid) data <= prev_data;
      end
   end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: selectable bitwise logic unit with a LATENCY-stage valid/ready pipeline and delivery counter
module logic_gate_pipe
   import logic_gate_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int LATENCY = 2,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             s_zero,
   output logic             s_ones,
   output logic [CNT_W-1:0] res_cnt
);

   localparam int DW = WIDTH + 2;

   logic [WIDTH-1:0] r;
   logic [LATENCY:0] v;
   logic [DW-1:0]    d [LATENCY:0];
   logic [LATENCY:1] nxt;

   assign r    = WIDTH'(gate_eval(gate_op_e'(op), MAX_W'(a), MAX_W'(b)));
   assign v[0] = in_valid;
   assign d[0] = {~|r, &r, r};

   // A stage's successor can take data when the consumer is ready or any later stage has a hole,
   // written flat so the ready path has no chained dependency between stages.
   for (genvar i = 1; i <= LATENCY; i++) begin : g_stage
      if (i == LATENCY) begin : g_last
         assign nxt[i] = out_ready;
      end else begin : g_mid
         assign nxt[i] = out_ready || !(&v[LATENCY:i+1]);
      end
      pipe_stage #(.W(DW)) u_stage (
         .clk       (clk),
         .rst       (rst),
         .prev_valid(v[i-1]),
         .prev_data (d[i-1]),
         .next_adv  (nxt[i]),
         .valid     (v[i]),
         .data      (d[i])
      );
   end

   assign in_ready              = !v[1] || nxt[1];
   assign out_valid             = v[LATENCY];
   assign {s_zero, s_ones, s}   = d[LATENCY];

   always_ff @(posedge clk) begin
      if (rst) res_cnt <= '0;
      else if (out_valid && out_ready && res_cnt != '1) res_cnt <= res_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: table-driven and directed-sequence checks of logic_gate_pipe with a result scoreboard
module tb_logic_gate_pipe;

   localparam int W = 8;
   localparam int L = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic [2:0]    op = '0;
   logic          in_ready, out_valid, s_zero, s_ones;
   logic [W-1:0]  s;
   logic [15:0]   res_cnt;
   logic          in_ready4, out_valid4, s_zero4, s_ones4;
   logic [W-1:0]  s4;
   logic [3:0]    res_cnt4;

   logic_gate_pipe #(.WIDTH(W), .LATENCY(L), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .s_zero(s_zero), .s_ones(s_ones),
      .res_cnt(res_cnt)
   );

   logic_gate_pipe #(.WIDTH(W), .LATENCY(L), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b), .op(op),
      .out_valid(out_valid4), .out_ready(out_ready), .s(s4), .s_zero(s_zero4), .s_ones(s_ones4),
      .res_cnt(res_cnt4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         z;
      logic         o;
   } vec_t;

   vec_t        tbl [10];
   logic [9:0]  q [$];
   int          checks = 0;
   int          errors = 0;
   int          deliv = 0;

   function automatic logic [9:0] model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] r;
      case (o)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: r = x ^ y;
         3'd3: r = ~(x & y);
         3'd4: r = ~(x | y);
         3'd5: r = ~(x ^ y);
         3'd6: r = x & ~y;
         default: r = x;
      endcase
      return {r == 8'h00, r == 8'hFF, r};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, exp);
      end
   endtask

   task automatic wait_edge();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accept queues its expected result, every delivery must match the oldest one.
   always @(negedge clk) begin
      if (rst) q.delete();
      else begin
         if (out_valid && out_ready) begin
            deliv++;
            if (q.size() == 0) chk("spurious_delivery", 64'(out_valid), 64'(0));
            else chk("sb_result", 64'({s_zero, s_ones, s}), 64'(q.pop_front()));
         end
         if (in_valid && in_ready) q.push_back(model(op, a, b));
      end
   end

   initial begin
      int n, nv, first, lastc, miss, idx, d0;
      tbl[0] = '{3'd0, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0};
      tbl[1] = '{3'd1, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0};
      tbl[2] = '{3'd2, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0};
      tbl[3] = '{3'd3, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0};
      tbl[4] = '{3'd4, 8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0};
      tbl[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0};
      tbl[6] = '{3'd6, 8'hF0, 8'hCC, 8'h30, 1'b0, 1'b0};
      tbl[7] = '{3'd7, 8'hF0, 8'hCC, 8'hF0, 1'b0, 1'b0};
      tbl[8] = '{3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1};
      tbl[9] = '{3'd0, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0};

      repeat (2) wait_edge();
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_s", 64'(s), 64'(0));
      chk("rst_s_zero", 64'(s_zero), 64'(0));
      chk("rst_s_ones", 64'(s_ones), 64'(0));
      chk("rst_res_cnt", 64'(res_cnt), 64'(0));
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 64'(in_ready), 64'(1));

      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1;
         op = tbl[i].op;
         a = tbl[i].a;
         b = tbl[i].b;
         wait_edge();
         in_valid = 1'b0;
         n = 0;
         while (!out_valid && n < 10) begin
            wait_edge();
            n++;
         end
         chk("vec_latency", 64'(n), 64'(L - 1));
         chk("vec_s", 64'(s), 64'(tbl[i].s));
         chk("vec_flags", 64'({s_zero, s_ones}), 64'({tbl[i].z, tbl[i].o}));
      end
      wait_edge();
      chk("vec_res_cnt", 64'(res_cnt), 64'(10));
      chk("vec_res_cnt4", 64'(res_cnt4), 64'(10));

      nv = 0; first = -1; lastc = -1; miss = 0;
      for (int c = 0; c < 30; c++) begin
         in_valid = (c < 16);
         op = 3'(c % 8);
         a = 8'(c * 17);
         b = 8'h5A ^ 8'(c);
         #1;
         if (out_valid) begin
            nv++;
            if (first < 0) first = c;
            lastc = c;
         end
         if (c < 16 && !in_ready) miss++;
         wait_edge();
      end
      chk("stream_ready_drops", 64'(miss), 64'(0));
      chk("stream_out_count", 64'(nv), 64'(16));
      chk("stream_contiguous", 64'(lastc - first), 64'(15));

      d0 = deliv;
      out_ready = 1'b0;
      idx = 0;
      in_valid = 1'b1;
      op = 3'd2; a = 8'h11; b = 8'h0F;
      for (int c = 0; c < 6; c++) begin
         #1;
         if (in_ready) begin
            wait_edge();
            idx++;
            a = 8'(8'h11 * (idx + 1));
         end else wait_edge();
      end
      chk("fill_accepts", 64'(idx), 64'(L));
      chk("fill_in_ready", 64'(in_ready), 64'(0));
      chk("fill_out_valid", 64'(out_valid), 64'(1));
      for (int c = 0; c < 3; c++) begin
         chk("stall_hold", 64'({s_zero, s_ones, s}), 64'(model(3'd2, 8'h11, 8'h0F)));
         wait_edge();
      end
      out_ready = 1'b1;
      #1;
      chk("full_pass_ready", 64'(in_ready), 64'(1));
      wait_edge();
      out_ready = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("full_occupancy_valid", 64'(out_valid), 64'(1));
      chk("full_occupancy_ready", 64'(in_ready), 64'(0));
      chk("full_head", 64'({s_zero, s_ones, s}), 64'(model(3'd2, 8'h22, 8'h0F)));
      out_ready = 1'b1;
      repeat (4) wait_edge();
      chk("drain_count", 64'(deliv - d0), 64'(3));
      chk("drain_empty", 64'(q.size()), 64'(0));

      out_ready = 1'b0;
      in_valid = 1'b1;
      op = 3'd1; a = 8'h01; b = 8'h02;
      wait_edge();
      a = 8'h04;
      wait_edge();
      in_valid = 1'b0;
      out_ready = 1'b1;
      rst = 1'b1;
      wait_edge();
      rst = 1'b0;
      chk("midrst_out_valid", 64'(out_valid), 64'(0));
      chk("midrst_res_cnt", 64'(res_cnt), 64'(0));
      chk("midrst_res_cnt4", 64'(res_cnt4), 64'(0));
      chk("midrst_in_ready", 64'(in_ready), 64'(1));
      nv = 0;
      repeat (5) begin
         wait_edge();
         if (out_valid) nv++;
      end
      chk("midrst_no_stale", 64'(nv), 64'(0));

      for (int c = 0; c < 20; c++) begin
         in_valid = 1'b1;
         op = 3'(c % 8);
         a = 8'(c);
         b = 8'(~c);
         wait_edge();
      end
      in_valid = 1'b0;
      repeat (4) wait_edge();
      chk("sat_res_cnt", 64'(res_cnt), 64'(20));
      chk("sat_res_cnt4", 64'(res_cnt4), 64'(15));
      chk("final_sb_empty", 64'(q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
